// File: rtl/key_debounce.sv
// key_debounce: push-button conditioner for the LED blinker.
// Two-flop synchroniser, counter-qualified four-state debounce FSM,
// registered level / press pulse / release pulse / blink enable.
// Optional build macro KEY_TOGGLE_EN: when defined, en toggles on every
// accepted press; when undefined, en follows the debounced level.
//
// state          | meaning
// ---------------+-------------------------------------------------
// S_RELEASED     | button accepted as released, waiting for a press
// S_PRESS_WAIT   | press seen, counting stable cycles to accept it
// S_PRESSED      | button accepted as held, waiting for a release
// S_RELEASE_WAIT | release seen, counting stable cycles to accept it

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int CNT_W           = 19,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic en
);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    // Pin level when the button is not pressed; also the synchroniser reset value.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             k_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pressed_nxt;
    logic             press_pulse_nxt;
    logic             release_pulse_nxt;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Normalise so that 1 always means "pressed".
    assign k_s = sync2 ^ IDLE_LVL;

    // State and qualification counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; the terminal compare fires before the counter could wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_RELEASED: begin
                if (k_s) begin
                    state_nxt = S_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!k_s) begin
                    state_nxt = S_RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_PRESSED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!k_s) begin
                    state_nxt = S_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (k_s) begin
                    state_nxt = S_PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_RELEASED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the transition being taken, so registered outputs
    // change on the same edge that the FSM enters the new state.
    always_comb begin
        pressed_nxt       = (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE_WAIT);
        press_pulse_nxt   = (state == S_PRESS_WAIT)   && (state_nxt == S_PRESSED);
        release_pulse_nxt = (state == S_RELEASE_WAIT) && (state_nxt == S_RELEASED);
    end

    // Registered outputs; reset clears them so interrupted transitions emit nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            en            <= 1'b0;
        end else begin
            pressed       <= pressed_nxt;
            press_pulse   <= press_pulse_nxt;
            release_pulse <= release_pulse_nxt;
`ifdef KEY_TOGGLE_EN
            en            <= en ^ press_pulse_nxt;
`else
            en            <= pressed_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// Directed vector table, hand-written corner sequences, then random
// key/reset activity checked against a run-length reference model.

module tb_key_debounce;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b1;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic en;

    int n_cmp = 0;
    int n_bad = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(19),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .en(en)
    );

    always #5 clk = ~clk;

    // Reference model: the pin passes through a 2-deep delay line, then the
    // accepted level flips once k_s has disagreed with it for D+1 edges in a row.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    logic m_level = 1'b0, m_pp = 1'b0, m_rp = 1'b0, m_en = 1'b0;
    int   m_run = 0;

    task automatic model_update(input logic r, input logic k);
        logic ks;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_level = 1'b0; m_run = 0;
            m_pp = 1'b0; m_rp = 1'b0; m_en = 1'b0;
        end else begin
            ks = ~m_s2;
            m_s2 = m_s1;
            m_s1 = k;
            m_pp = 1'b0;
            m_rp = 1'b0;
            if (ks != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = ks;
                    m_run = 0;
                    m_pp = ks;
                    m_rp = ~ks;
`ifdef KEY_TOGGLE_EN
                    if (ks) m_en = ~m_en;
`endif
                end
            end else begin
                m_run = 0;
            end
`ifndef KEY_TOGGLE_EN
            m_en = m_level;
`endif
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One clock edge: drive on the falling edge, check #1 after the rising edge.
    task automatic step(input logic r, input logic k);
        @(negedge clk);
        rst = r;
        key = k;
        @(posedge clk);
        model_update(r, k);
        #1;
        chk("model_pressed", pressed, m_level);
        chk("model_press_pulse", press_pulse, m_pp);
        chk("model_release_pulse", release_pulse, m_rp);
        chk("model_en", en, m_en);
        chk("pulse_exclusive", press_pulse & release_pulse, 1'b0);
    endtask

    typedef struct {
        logic rst;
        logic key;
        logic pressed;
        logic pp;
        logic rp;
        logic en;
    } vec_t;

    vec_t vec[$];

    function automatic void add(input logic r, input logic k, input logic p,
                                input logic pp, input logic rp, input logic e);
        vec_t v;
        v.rst = r; v.key = k; v.pressed = p; v.pp = pp; v.rp = rp; v.en = e;
        vec.push_back(v);
    endfunction

    initial begin
        int rp_count;
        int run;
        logic rk;
        logic rr;

        // Reset with key released, then idle for 20 cycles.
        for (int i = 0; i < 3; i++)  add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Clean press: edge i (1-based) is the i-th edge sampling key=0.
        for (int i = 1; i <= 10; i++)
            add(1'b0, 1'b0, i >= 7, i == 7, 1'b0, i >= 7);
        // Clean release.
        for (int i = 1; i <= 10; i++)
`ifdef KEY_TOGGLE_EN
            add(1'b0, 1'b1, i < 7, 1'b0, i == 7, 1'b1);
`else
            add(1'b0, 1'b1, i < 7, 1'b0, i == 7, i < 7);
`endif
        // Second press.
        for (int i = 1; i <= 10; i++)
`ifdef KEY_TOGGLE_EN
            add(1'b0, 1'b0, i >= 7, i == 7, 1'b0, i < 7);
`else
            add(1'b0, 1'b0, i >= 7, i == 7, 1'b0, i >= 7);
`endif

        foreach (vec[i]) begin
            step(vec[i].rst, vec[i].key);
            chk("vec_pressed", pressed, vec[i].pressed);
            chk("vec_press_pulse", press_pulse, vec[i].pp);
            chk("vec_release_pulse", release_pulse, vec[i].rp);
            chk("vec_en", en, vec[i].en);
        end

        // Release bounce from PRESSED: 2-cycle glitch, back to pressed, then release.
        rp_count = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            chk("rb_glitch_pressed", pressed, 1'b1);
            chk("rb_glitch_release_pulse", release_pulse, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("rb_hold_pressed", pressed, 1'b1);
            chk("rb_hold_release_pulse", release_pulse, 1'b0);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1);
            chk("rb_pressed", pressed, i < 7);
            chk("rb_release_pulse", release_pulse, i == 7);
            if (release_pulse) rp_count++;
        end
        chk("rb_single_release", rp_count == 1, 1'b1);

        // Press bounce rejection: 0x3, 1x1, 0x3, then released.
        for (int i = 0; i < 17; i++) begin
            step(1'b0, (i == 3 || i >= 7) ? 1'b1 : 1'b0);
            chk("br_pressed", pressed, 1'b0);
            chk("br_press_pulse", press_pulse, 1'b0);
            chk("br_en", en, 1'b0);
        end

        // Reset mid-debounce: reach PRESS_WAIT cnt=2, reset with key held low.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk("rm_pre_pressed", pressed, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("rm_rst_press_pulse", press_pulse, 1'b0);
            chk("rm_rst_pressed", pressed, 1'b0);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0);
            chk("rm_press_pulse", press_pulse, i == 7);
            chk("rm_pressed", pressed, i >= 7);
        end

        // Random key runs with occasional reset, checked against the model.
        run = 0;
        rk = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                rk = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 12);
            end
            run--;
            rr = ($urandom_range(0, 249) == 0);
            step(rr, rk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
